// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between the requester clients, the shared UART transmitter and
// the round-robin arbiter.
//   req        : per-requester level request
//   req_data   : requester i's byte at [i*DATA_W +: DATA_W]
//   gnt        : one-hot, one-cycle grant pulse
//   tx_newd    : transmitter newd
//   tx_dintx   : transmitter data in
//   tx_done    : transmitter donetx (rising edge is used)
//   busy       : arbiter is not idle
//   cur_id     : current / last granted requester
//   done_pulse : byte completed
//   err_pulse  : byte aborted by watchdog
// master: clients + transmitter side; slave: the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      tx_newd;
  logic [DATA_W-1:0]         tx_dintx;
  logic                      tx_done;
  logic                      busy;
  logic [ID_W-1:0]           cur_id;
  logic                      done_pulse;
  logic                      err_pulse;

  modport master (
    output req, req_data, tx_done,
    input  gnt, tx_newd, tx_dintx, busy, cur_id, done_pulse, err_pulse
  );

  modport slave (
    input  req, req_data, tx_done,
    output gnt, tx_newd, tx_dintx, busy, cur_id, done_pulse, err_pulse
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Grants one requester, holds tx_newd for NEWD_HOLD cycles, then waits for a
// rising edge of tx_done; a watchdog aborts after TIMEOUT_CYC cycles.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : uart_tx_arbiter_if.slave (requests, grants, transmitter, status)
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NEWD_HOLD   = 104,
  parameter int unsigned TIMEOUT_CYC = 2048
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned ID_W   = $clog2(NUM_REQ);
  localparam int unsigned HOLD_W = $clog2(NEWD_HOLD + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic              done_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TO_W-1:0]   to_cnt;

  logic              found_c;
  logic [ID_W-1:0]   win_c;
  logic              done_rise_c;
  logic [ID_W-1:0]   next_ptr_c;

  // Winner: first set request bit scanning ptr, ptr+1, ... modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    found_c = 1'b0;
    win_c   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found_c && bus.req[idx]) begin
        found_c = 1'b1;
        win_c   = ID_W'(idx);
      end
    end
  end

  assign done_rise_c = bus.tx_done & ~done_q;
  assign next_ptr_c  = (bus.cur_id == ID_W'(NUM_REQ - 1)) ? '0 : bus.cur_id + ID_W'(1);

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      done_q         <= 1'b0;
      hold_cnt       <= '0;
      to_cnt         <= '0;
      bus.gnt        <= '0;
      bus.tx_newd    <= 1'b0;
      bus.tx_dintx   <= '0;
      bus.busy       <= 1'b0;
      bus.cur_id     <= '0;
      bus.done_pulse <= 1'b0;
      bus.err_pulse  <= 1'b0;
    end else begin
      done_q         <= bus.tx_done;
      bus.gnt        <= '0;
      bus.done_pulse <= 1'b0;
      bus.err_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (found_c) begin
            bus.gnt      <= NUM_REQ'(1) << win_c;
            bus.cur_id   <= win_c;
            bus.tx_dintx <= bus.req_data[int'(win_c)*DATA_W +: DATA_W];
            bus.tx_newd  <= 1'b1;
            bus.busy     <= 1'b1;
            hold_cnt     <= HOLD_W'(1);
            to_cnt       <= TO_W'(1);
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          // tx_done edges here are stale and deliberately ignored.
          if (to_cnt < TO_W'(TIMEOUT_CYC)) to_cnt <= to_cnt + TO_W'(1);
          if (hold_cnt >= HOLD_W'(NEWD_HOLD)) begin
            bus.tx_newd <= 1'b0;
            state       <= WAIT;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        WAIT: begin
          // Completion takes priority over a coincident timeout.
          if (done_rise_c) begin
            bus.done_pulse <= 1'b1;
            bus.busy       <= 1'b0;
            ptr            <= next_ptr_c;
            state          <= IDLE;
          end else if (to_cnt >= TO_W'(TIMEOUT_CYC)) begin
            bus.err_pulse <= 1'b1;
            bus.busy      <= 1'b0;
            ptr           <= next_ptr_c;
            state         <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed request patterns push the
// expected grant/done/err events; a monitor pops and compares them.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned NEWD_HOLD   = 4;
  localparam int unsigned TIMEOUT_CYC = 64;

  logic clk;
  logic rst;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .NEWD_HOLD  (NEWD_HOLD),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef enum int {K_GNT, K_DONE, K_ERR} kind_t;
  typedef struct {
    kind_t      kind;
    int         id;
    logic [7:0] data;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   tx_delay = 20;
  bit   tx_en = 1'b1;
  bit   stale_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act === req_v) passed++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req_v, $time);
  endtask

  task automatic push_ev(input kind_t k, input int id, input logic [7:0] d, input int lat);
    exp_t e;
    e.kind = k;
    e.id   = id;
    e.data = d;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  // Grant followed by its completion; done latency is NEWD_HOLD + 1 + delay = 25
  // with the default 20-cycle transmitter model.
  task automatic push_xfer(input int id, input logic [7:0] d, input kind_t fin, input int lat);
    push_ev(K_GNT, id, d, 0);
    push_ev(fin, id, d, lat);
  endtask

  task automatic set_data(input int i, input logic [7:0] d);
    bus.req_data[i*8 +: 8] = d;
  endtask

  // Drive a request pattern; each bit drops on its grant, after which the
  // granted byte is corrupted to prove tx_dintx was captured.
  task automatic run(input logic [3:0] r, input int budget);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    bus.req = r;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < 4; i++) begin
        if (bus.gnt[i]) begin
          bus.req[i] = 1'b0;
          bus.req_data[i*8 +: 8] = ~bus.req_data[i*8 +: 8];
        end
      end
      if (bus.req == 4'b0000 && !bus.busy) ok = 1'b1;
    end
    check("run_in_budget", 32'(ok), 32'd1);
  endtask

  // Transmitter model: done pulse tx_delay cycles after tx_newd falls, and an
  // optional stale pulse shortly after tx_newd rises.
  initial begin : tx_model
    int done_cnt;
    int stale_cnt;
    bit newd_prev;
    done_cnt    = 0;
    stale_cnt   = 0;
    newd_prev   = 1'b0;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (rst) begin
        done_cnt  = 0;
        stale_cnt = 0;
      end else begin
        if (stale_cnt > 0) begin
          stale_cnt--;
          if (stale_cnt == 0) bus.tx_done = 1'b1;
        end
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) bus.tx_done = 1'b1;
        end
        if (bus.tx_newd && !newd_prev && stale_en) stale_cnt = 2;
        if (!bus.tx_newd && newd_prev && tx_en) done_cnt = tx_delay;
      end
      newd_prev = bus.tx_newd;
    end
  end

  initial begin : monitor
    int   cyc;
    int   gnt_cyc;
    int   newd_run;
    exp_t e;
    cyc      = 0;
    gnt_cyc  = 0;
    newd_run = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        newd_run = 0;
      end else begin
        if (bus.tx_newd) newd_run++;
        else if (newd_run != 0) begin
          check("newd_len", 32'(newd_run), 32'(NEWD_HOLD));
          newd_run = 0;
        end
        if (bus.gnt != '0) begin
          check("gnt_onehot", 32'($onehot(bus.gnt)), 32'd1);
          check("sb_pending_gnt", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("gnt_kind", 32'(K_GNT), 32'(e.kind));
            check("gnt_vec", 32'(bus.gnt), 32'd1 << e.id);
            check("gnt_cur_id", 32'(bus.cur_id), 32'(e.id));
            check("gnt_dintx", 32'(bus.tx_dintx), 32'(e.data));
            check("gnt_newd", 32'(bus.tx_newd), 32'd1);
            check("gnt_busy", 32'(bus.busy), 32'd1);
          end
          gnt_cyc = cyc;
        end
        if (bus.done_pulse || bus.err_pulse) begin
          check("pulse_excl", 32'(bus.done_pulse & bus.err_pulse), 32'd0);
          check("end_gnt_low", 32'(bus.gnt), 32'd0);
          check("end_busy", 32'(bus.busy), 32'd0);
          check("sb_pending_end", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("end_kind", bus.done_pulse ? 32'(K_DONE) : 32'(K_ERR), 32'(e.kind));
            check("end_cur_id", 32'(bus.cur_id), 32'(e.id));
            check("end_dintx", 32'(bus.tx_dintx), 32'(e.data));
            check("end_latency", 32'(cyc - gnt_cyc), 32'(e.lat));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit got;
    bus.req      = '0;
    bus.req_data = '0;
    rst          = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_newd", 32'(bus.tx_newd), 32'd0);
    check("rst_dintx", 32'(bus.tx_dintx), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cur_id", 32'(bus.cur_id), 32'd0);
    check("rst_done", 32'(bus.done_pulse), 32'd0);
    check("rst_err", 32'(bus.err_pulse), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: single requester
    set_data(0, 8'hAA);
    push_xfer(0, 8'hAA, K_DONE, 25);
    run(4'b0001, 200);
    @(negedge clk);
    check("t1_busy_after", 32'(bus.busy), 32'd0);

    // 2: all requesting; ptr is 1 after serving 0, so order is 1,2,3,0
    set_data(0, 8'h11);
    set_data(1, 8'h22);
    set_data(2, 8'h33);
    set_data(3, 8'h44);
    push_xfer(1, 8'h22, K_DONE, 25);
    push_xfer(2, 8'h33, K_DONE, 25);
    push_xfer(3, 8'h44, K_DONE, 25);
    push_xfer(0, 8'h11, K_DONE, 25);
    run(4'b1111, 600);
    set_data(0, 8'h5A);
    push_xfer(0, 8'h5A, K_DONE, 25);
    run(4'b0001, 200);

    // 3: fairness; serve 2 (ptr -> 3), then 0101 scans 3,0 -> 0, then 2
    set_data(2, 8'hC3);
    push_xfer(2, 8'hC3, K_DONE, 25);
    run(4'b0100, 200);
    set_data(0, 8'h0F);
    set_data(2, 8'hF0);
    push_xfer(0, 8'h0F, K_DONE, 25);
    push_xfer(2, 8'hF0, K_DONE, 25);
    run(4'b0101, 400);

    // 4: timeout on requester 1, then recovery grants 3 (ptr -> 2)
    tx_en = 1'b0;
    set_data(1, 8'h99);
    push_xfer(1, 8'h99, K_ERR, 64);
    run(4'b0010, 200);
    tx_en = 1'b1;
    set_data(3, 8'h3C);
    push_xfer(3, 8'h3C, K_DONE, 25);
    run(4'b1000, 200);

    // 6: stale done during ISSUE is ignored; done coincident with timeout wins
    stale_en = 1'b1;
    set_data(0, 8'hA5);
    push_xfer(0, 8'hA5, K_DONE, 25);
    run(4'b0001, 200);
    stale_en = 1'b0;
    tx_delay = 59;
    set_data(2, 8'h7E);
    push_xfer(2, 8'h7E, K_DONE, 64);
    run(4'b0100, 200);
    tx_delay = 20;

    // 5: reset during ISSUE, then ptr must be back at 0
    set_data(0, 8'hE1);
    push_ev(K_GNT, 0, 8'hE1, 0);
    bus.req = 4'b0001;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (bus.gnt != '0) got = 1'b1;
    end
    check("t5_granted", 32'(got), 32'd1);
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);
    check("t5_newd_before", 32'(bus.tx_newd), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("t5_rst_newd", 32'(bus.tx_newd), 32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_gnt", 32'(bus.gnt), 32'd0);
    check("t5_rst_dintx", 32'(bus.tx_dintx), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_data(1, 8'hB1);
    set_data(3, 8'hB3);
    push_xfer(1, 8'hB1, K_DONE, 25);
    push_xfer(3, 8'hB3, K_DONE, 25);
    run(4'b1010, 400);

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
